message_schedule_gen: RTL and testbench
=======================================

MESSAGE_SCHEDULE_GEN -- requirements
Module: message_schedule_gen

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 64, giving the number of W words emitted per block (legal range 16..64).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port blk_valid  input  1  512-bit block offered.
REQ-005 The block SHALL have port blk_ready  output  1  block can be accepted.
REQ-006 The block SHALL have port blk_data  input  [0:511]  words M[0..15], where M[i] occupies bits 32i..32i+31 and bit 0 is the MSB of M[0].
REQ-007 The block SHALL have port w_valid  output  1  W word available.
REQ-008 The block SHALL have port w_ready  input  1  consumer (compression round) takes word.
REQ-009 The block SHALL have port w_data  output  [0:31]  W[t], bit 0 = MSB.
REQ-010 The block SHALL have port w_idx  output  [0:5]  t of the current w_data.
REQ-011 The block SHALL have port w_last  output  1  high with w_valid when t = ROUNDS-1.
REQ-012 The block SHALL have port busy  output  1  high in RUN.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (blk_ready=1, w_valid=0) and RUN (blk_ready=0, w_valid=1).
REQ-014 Block accept SHALL occur when blk_valid and blk_ready are both high on a clock edge: load a 16-word window win[0..15]=M[0..15], set t=0, enter RUN, with w_valid high the next cycle (one-cycle latency).
REQ-015 A transfer SHALL occur when w_valid and w_ready are both high: advance t; shift win[k]<=win[k+1] for k=0..14; win[15]<=σ1(win[14])+win[9]+σ0(win[1])+win[0], mod 2^32.
REQ-016 w_data SHALL equal win[0]; thus W[t]=M[t] for t<16, and W[t] follows the FIPS 180-4 recurrence for t>=16.
REQ-017 The sigma functions SHALL be σ0(x)=ROTR7^ROTR18^SHR3 and σ1(x)=ROTR17^ROTR19^SHR10.
REQ-018 w_data, w_idx and w_last SHALL hold stable while w_valid=1 and w_ready=0, with no limit on stall length.
REQ-019 A transfer with w_last=1 SHALL return the FSM to IDLE, so blk_ready=1 and w_valid=0 on the next cycle; blocks SHALL NOT overlap.
REQ-020 Back-to-back operation SHALL give a minimum of ROUNDS+1 cycles per block; the block is accepted on the first IDLE cycle.
REQ-021 blk_data SHALL be sampled only on the accept edge and ignored otherwise.
REQ-022 Window, t and outputs SHALL NOT change in IDLE; w_data, w_idx and w_last SHALL drop to 0 on the return to IDLE.

Reset
REQ-023 rst_n low SHALL immediately, without a clock, force IDLE, window=0, t=0, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0, blk_ready=1.
REQ-024 Reset mid-block SHALL discard the block; no partial W words are emitted afterwards.
REQ-025 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro SCHED_ABORT_EN, when defined, SHALL add port abort  input  1  discard current block.
REQ-027 With SCHED_ABORT_EN, abort high in RUN SHALL force IDLE on the next edge and clear window, t and w outputs.
REQ-028 With SCHED_ABORT_EN, a transfer coincident with abort SHALL still count as consumed.
REQ-029 With SCHED_ABORT_EN, abort high in IDLE SHALL block any accept that cycle, and SHALL have no other effect.
REQ-030 Without SCHED_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be identical to abort tied 0.

Verification
REQ-031 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with w_ready=1 -> W0=0x61626380, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; w_last only at w_idx=63; blk_ready high on the cycle after.
REQ-032 Same block with w_ready low for 5 cycles at w_idx=20 -> w_data/w_idx unchanged across the stall; full sequence identical to REQ-031.
REQ-033 blk_valid held high with two blocks (the all-zero block, then "abc") -> 64 zero words, one IDLE cycle, then the "abc" sequence; total 130 cycles.
REQ-034 rst_n pulsed low at w_idx=30 -> outputs 0 and blk_ready=1 asynchronously; the next block starts at w_idx=0 with correct values.
REQ-035 With SCHED_ABORT_EN: abort at w_idx=10 while blk_valid=1 -> IDLE next cycle, no accept that cycle, the new block is accepted on the following edge and W0 equals its M0.
REQ-036 ROUNDS=16 with the "abc" block -> exactly 16 words equal to M0..M15, with w_last at w_idx=15.

Source files
------------

// File: rtl/message_schedule_gen.sv
// SHA-256 message schedule: expands one 512-bit block into ROUNDS W words over a valid/ready stream.
// Optional abort input is compiled in when SCHED_ABORT_EN is defined.
module message_schedule_gen #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [0:511] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [0:31]  w_data,
    output logic [0:5]   w_idx,
    output logic         w_last,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [31:0] win_reg  [16];
    logic [31:0] win_next [16];
    logic [5:0]  t_reg;
    logic        abort_i;
    logic        accept;
    logic        xfer;
    logic        at_last;
    logic        load;
    logic        shift;
    logic        clear;
    logic [31:0] new_word;

`ifdef SCHED_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign blk_ready = (state_reg == IDLE);
    assign w_valid   = (state_reg == RUN);
    assign busy      = w_valid;
    assign at_last   = (t_reg == LAST_T);
    assign accept    = blk_valid && blk_ready && !abort_i;
    assign xfer      = w_valid && w_ready;
    assign w_data    = win_reg[0];
    assign w_idx     = t_reg;
    assign w_last    = w_valid && at_last;
    assign new_word  = sigma1(win_reg[14]) + win_reg[9] + sigma0(win_reg[1]) + win_reg[0];

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        shift      = 1'b0;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                // Abort wins over shifting; a coincident transfer is simply consumed.
                if (abort_i || (xfer && at_last)) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (xfer) begin
                    shift = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            logic [31:0] shift_in;
            if (gi == 15) begin : g_tail
                assign shift_in = new_word;
            end else begin : g_body
                assign shift_in = win_reg[gi+1];
            end
            assign win_next[gi] = clear ? 32'd0 :
                                  load  ? blk_data[32*gi +: 32] :
                                  shift ? shift_in : win_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                win_reg[k] <= 32'd0;
            end
            t_reg <= 6'd0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                win_reg[k] <= win_next[k];
            end
            if (clear || load) begin
                t_reg <= 6'd0;
            end else if (shift) begin
                t_reg <= t_reg + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_message_schedule_gen.sv
// Randomised and directed checks of message_schedule_gen against a FIPS 180-4 schedule model.
// Abort steps are compiled in when SCHED_ABORT_EN is defined.
module tb_message_schedule_gen;

    typedef logic [31:0] m_arr_t [16];
    typedef logic [31:0] w_arr_t [64];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [0:511] blk_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b0;
    logic [0:31]  w_data;
    logic [0:5]   w_idx;
    logic         w_last;
    logic         busy;

    logic         blk_valid16 = 1'b0;
    logic         blk_ready16;
    logic [0:511] blk_data16 = '0;
    logic         w_valid16;
    logic         w_ready16 = 1'b0;
    logic [0:31]  w_data16;
    logic [0:5]   w_idx16;
    logic         w_last16;
    logic         busy16;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    w_arr_t got;

    always #5 clk = ~clk;

    message_schedule_gen #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SCHED_ABORT_EN
        .abort(abort),
`endif
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
        .w_last(w_last), .busy(busy)
    );

    message_schedule_gen #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
`ifdef SCHED_ABORT_EN
        .abort(1'b0),
`endif
        .blk_valid(blk_valid16), .blk_ready(blk_ready16), .blk_data(blk_data16),
        .w_valid(w_valid16), .w_ready(w_ready16), .w_data(w_data16), .w_idx(w_idx16),
        .w_last(w_last16), .busy(busy16)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic w_arr_t expand(input m_arr_t m);
        w_arr_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        return w;
    endfunction

    function automatic logic [0:511] pack(input m_arr_t m);
        logic [0:511] p;
        for (int i = 0; i < 16; i++) p[32*i +: 32] = m[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".w_valid"}, w_valid, 0);
        check({tag, ".blk_ready"}, blk_ready, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".w_data"}, w_data, 0);
        check({tag, ".w_idx"}, w_idx, 0);
        check({tag, ".w_last"}, w_last, 0);
    endtask

    // Called at a negedge where W0 is on the bus; returns at the negedge after nr transfers.
    // mode 0: always ready, 1: 5-cycle stall at stall_at, 2: random ready.
    task automatic stream(input w_arr_t exp, input int nr, input int mode, input int stall_at);
        int t = 0;
        int stalls = 0;
        int guard = 0;
        while (t < nr && guard < 2000) begin
            check("w_valid", w_valid, 1);
            check("w_idx", w_idx, t);
            check("w_data", w_data, exp[t]);
            check("w_last", w_last, t == 63);
            got[t] = w_data;
            if (mode == 1 && t == stall_at && stalls < 5) begin
                w_ready = 1'b0;
                stalls++;
            end else if (mode == 2) begin
                w_ready = ($urandom_range(0, 3) != 0);
            end else begin
                w_ready = 1'b1;
            end
            if (w_ready) t++;
            @(negedge clk);
            cyc++;
            guard++;
        end
        if (guard >= 2000) begin
            total++;
            bad++;
            $error("FAIL stream_timeout observed=%0d expected=%0d", t, nr);
        end
    endtask

    task automatic offer(input m_arr_t m);
        blk_valid = 1'b1;
        blk_data  = pack(m);
        @(negedge clk);
        cyc++;
        blk_valid = 1'b0;
        blk_data  = {16{$urandom()}};
    endtask

    m_arr_t abc;
    m_arr_t zero;
    m_arr_t rnd;
    w_arr_t exp_abc;
    w_arr_t exp_zero;
    w_arr_t exp_rnd;

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'd0;
            zero[i] = 32'd0;
        end
        abc[0]   = 32'h61626380;
        abc[15]  = 32'h00000018;
        exp_abc  = expand(abc);
        exp_zero = expand(zero);

        // Reset state, then the first accept on the first edge after release.
        #1;
        idle_check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        offer(abc);
        stream(exp_abc, 64, 0, 0);
        idle_check("abc_end");
        check("abc_W0", got[0], 32'h61626380);
        check("abc_W16", got[16], 32'h61626380);
        check("abc_W17", got[17], 32'h000F0000);
        check("abc_W63", got[63], 32'h12B1EDEB);
        $display("block abc w63=%08h", got[63]);

        // Consumer stall at w_idx=20.
        offer(abc);
        stream(exp_abc, 64, 1, 20);
        idle_check("stall_end");
        check("stall_W63", got[63], 32'h12B1EDEB);
        $display("block abc_stall w63=%08h", got[63]);

        // Back-to-back with blk_valid held high: zero block then abc.
        cyc = 0;
        blk_valid = 1'b1;
        blk_data  = pack(zero);
        @(negedge clk);
        cyc++;
        blk_data = pack(abc);
        stream(exp_zero, 64, 0, 0);
        idle_check("b2b_gap");
        @(negedge clk);
        cyc++;
        blk_valid = 1'b0;
        stream(exp_abc, 64, 0, 0);
        idle_check("b2b_end");
        check("b2b_cycles", cyc, 130);
        $display("block b2b cycles=%0d", cyc);

        // Random blocks with random back-pressure.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom();
            exp_rnd = expand(rnd);
            offer(rnd);
            stream(exp_rnd, 64, 2, 0);
            idle_check("rnd_end");
            $display("block rnd%0d w63=%08h", n, got[63]);
        end

        // Asynchronous reset mid-block at w_idx=30.
        for (int i = 0; i < 16; i++) rnd[i] = $urandom();
        exp_rnd = expand(rnd);
        offer(rnd);
        stream(exp_rnd, 30, 0, 0);
        check("pre_rst_idx", w_idx, 30);
        #1 rst_n = 1'b0;
        #1 idle_check("async_rst");
        blk_valid = 1'b1;
        blk_data  = pack(abc);
        #1 rst_n = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        stream(exp_abc, 64, 0, 0);
        idle_check("post_rst_end");
        $display("block after_reset w63=%08h", got[63]);

`ifdef SCHED_ABORT_EN
        // Abort at w_idx=10 with a new block already offered.
        offer(abc);
        stream(exp_abc, 10, 0, 0);
        for (int i = 0; i < 16; i++) rnd[i] = $urandom();
        exp_rnd = expand(rnd);
        abort = 1'b1;
        blk_valid = 1'b1;
        blk_data = pack(rnd);
        w_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle_check("abort_idle");
        @(negedge clk);
        blk_valid = 1'b0;
        stream(exp_rnd, 64, 0, 0);
        idle_check("abort_next_end");
        $display("block after_abort w0=%08h", got[0]);

        // Abort in IDLE only suppresses that cycle's accept.
        abort = 1'b1;
        blk_valid = 1'b1;
        blk_data = pack(abc);
        @(negedge clk);
        abort = 1'b0;
        idle_check("abort_in_idle");
        @(negedge clk);
        blk_valid = 1'b0;
        stream(exp_abc, 64, 0, 0);
        idle_check("abort_in_idle_end");
        $display("block abort_in_idle w63=%08h", got[63]);
`endif

        // ROUNDS=16 instance emits exactly M0..M15.
        blk_valid16 = 1'b1;
        blk_data16  = pack(abc);
        @(negedge clk);
        blk_valid16 = 1'b0;
        w_ready16   = 1'b1;
        for (int t = 0; t < 16; t++) begin
            check("r16_w_valid", w_valid16, 1);
            check("r16_w_idx", w_idx16, t);
            check("r16_w_data", w_data16, abc[t]);
            check("r16_w_last", w_last16, t == 15);
            @(negedge clk);
        end
        check("r16_end_valid", w_valid16, 0);
        check("r16_end_ready", blk_ready16, 1);
        check("r16_end_data", w_data16, 0);
        $display("block rounds16 done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
